// File: rtl/scan_inject_ctrl_pkg.sv
// Package for the scan injection controller: FSM state encoding, default
// chain/capture sizes and the phase-counter width helper.
package scan_inject_pkg;

  localparam int DEF_CHAIN_LEN = 16;
  localparam int DEF_CAP_W     = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } stateT;

  // The single phase counter must hold both CHAIN_LEN-1 and cap_cycles-1.
  function automatic int cntWidth(input int chainLen, input int capW);
    int w;
    w = $clog2(chainLen + 1);
    return (w > capW) ? w : capW;
  endfunction

endpackage

// File: rtl/scan_inject_ctrl_if.sv
// Bundle between campaign driver / netlist scan pins and the controller.
// Optional compare feature: SCAN_COMPARE_EN adds expected/mismatch.
interface scan_inject_ctrl_if import scan_inject_pkg::*; #(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CAP_W     = DEF_CAP_W
);

  logic                 start;
  logic                 abort;
  logic [CHAIN_LEN-1:0] pattern;
  logic [CAP_W-1:0]     cap_cycles;
  logic                 scan_out;
  logic                 scan_en;
  logic                 scan_in;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] response;
`ifdef SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] expected;
  logic                 mismatch;

  modport master (output start, abort, pattern, cap_cycles, scan_out, expected,
                  input  scan_en, scan_in, busy, done, response, mismatch);
  modport slave  (input  start, abort, pattern, cap_cycles, scan_out, expected,
                  output scan_en, scan_in, busy, done, response, mismatch);
`else
  modport master (output start, abort, pattern, cap_cycles, scan_out,
                  input  scan_en, scan_in, busy, done, response);
  modport slave  (input  start, abort, pattern, cap_cycles, scan_out,
                  output scan_en, scan_in, busy, done, response);
`endif

endinterface

// File: rtl/scan_inject_ctrl_phase_cnt.sv
// Down-counter timing the SHIFT_IN, CAPTURE and SHIFT_OUT phases.
// zero marks the last cycle of the current phase; it never wraps.
module scan_phase_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] loadVal,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (!rst_n)                  count <= '0;
    else if (load)               count <= loadVal;
    else if (dec && count != '0) count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/scan_inject_ctrl.sv
// Scan-chain sequencer for fault-injection campaigns:
// shift pattern in, run capture cycles, shift response out.
// Optional compare feature: SCAN_COMPARE_EN.
module scan_inject_ctrl import scan_inject_pkg::*; #(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CAP_W     = DEF_CAP_W
) (
  input  logic clk,
  input  logic rst_n,
  scan_inject_ctrl_if.slave bus,
  output stateT dbgState
);

  // Handshake: start is a request that is taken only in IDLE (busy=0 and not
  // in DONE) with abort low; there is no queuing, so a driver waits for
  // done or busy=0 before requesting again. done is a one-cycle completion
  // strobe with response valid; abort outside IDLE cancels without done.

  localparam int CNT_W = cntWidth(CHAIN_LEN, CAP_W);
  localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(CHAIN_LEN - 1);

  stateT state, nextState;
  logic accept, abortHit;
  logic cntLoad, cntDec, cntZero;
  logic [CNT_W-1:0] cntLoadVal, capM1;
  logic [CHAIN_LEN-1:0] patSr, respSr, respNext;
  logic scanEnD, scanInD, busyD, doneD;
  logic scanEnQ, scanInQ, busyQ, doneQ;
`ifdef SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] expLat;
  logic mismatchQ;
`endif

  assign accept   = (state == IDLE) && bus.start && !bus.abort;
  assign abortHit = (state != IDLE) && bus.abort;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic; abort returns to IDLE from any active state.
  always_comb begin
    nextState = state;
    if (abortHit) nextState = IDLE;
    else begin
      case (state)
        IDLE:      if (accept)  nextState = SHIFT_IN;
        SHIFT_IN:  if (cntZero) nextState = CAPTURE;
        CAPTURE:   if (cntZero) nextState = SHIFT_OUT;
        SHIFT_OUT: if (cntZero) nextState = DONE;
        DONE:                   nextState = IDLE;
        default:                nextState = IDLE;
      endcase
    end
  end

  // Output decode: values for the next cycle, registered below.
  always_comb begin
    scanEnD = (nextState == SHIFT_IN) || (nextState == SHIFT_OUT);
    busyD   = (nextState == SHIFT_IN) || (nextState == CAPTURE) || (nextState == SHIFT_OUT);
    doneD   = (nextState == DONE);
    scanInD = 1'b0;
    if (accept) scanInD = bus.pattern[CHAIN_LEN-1];
    else if (state == SHIFT_IN && !cntZero && !abortHit) scanInD = patSr[CHAIN_LEN-1];
  end

  // Phase counter control: reload at each phase boundary, clear on abort.
  always_comb begin
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    if (abortHit) begin
      cntLoad = 1'b1;
    end else if (accept) begin
      cntLoad    = 1'b1;
      cntLoadVal = LEN_M1;
    end else if (cntZero && state == SHIFT_IN) begin
      cntLoad    = 1'b1;
      cntLoadVal = capM1;
    end else if (cntZero && state == CAPTURE) begin
      cntLoad    = 1'b1;
      cntLoadVal = LEN_M1;
    end
  end

  assign cntDec = !cntLoad;

  scan_phase_cnt #(.W(CNT_W)) uPhaseCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cntLoad),
    .dec     (cntDec),
    .loadVal (cntLoadVal),
    .zero    (cntZero)
  );

  // Response shifts in at the LSB so the first bit out lands in the MSB.
  always_comb begin
    respNext    = respSr << 1;
    respNext[0] = bus.scan_out;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      patSr   <= '0;
      respSr  <= '0;
      capM1   <= '0;
      scanEnQ <= 1'b0;
      scanInQ <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
`ifdef SCAN_COMPARE_EN
      expLat    <= '0;
      mismatchQ <= 1'b0;
`endif
    end else begin
      scanEnQ <= scanEnD;
      scanInQ <= scanInD;
      busyQ   <= busyD;
      doneQ   <= doneD;
      if (accept) begin
        patSr  <= bus.pattern << 1;
        respSr <= '0;
        capM1  <= (bus.cap_cycles == '0) ? '0 : CNT_W'(bus.cap_cycles - CAP_W'(1));
`ifdef SCAN_COMPARE_EN
        expLat    <= bus.expected;
        mismatchQ <= 1'b0;
`endif
      end else begin
        if (state == SHIFT_IN)  patSr  <= patSr << 1;
        if (state == SHIFT_OUT) respSr <= respNext;
`ifdef SCAN_COMPARE_EN
        if (state == SHIFT_OUT && cntZero && !abortHit) mismatchQ <= |(respNext ^ expLat);
`endif
      end
    end
  end

  assign bus.scan_en  = scanEnQ;
  assign bus.scan_in  = scanInQ;
  assign bus.busy     = busyQ;
  assign bus.done     = doneQ;
  assign bus.response = respSr;
`ifdef SCAN_COMPARE_EN
  assign bus.mismatch = mismatchQ;
`endif
  assign dbgState = state;

endmodule

// File: tb/tb_scan_inject_ctrl.sv
// Bench for scan_inject_ctrl with a behavioural scan-chain model.
// Compare feature tested when SCAN_COMPARE_EN is defined.
module tb_scan_inject_ctrl;
  import scan_inject_pkg::*;

  localparam int CL = 16;
  localparam int CW = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stateT dbgState;
  scan_inject_ctrl_if #(.CHAIN_LEN(CL), .CAP_W(CW)) bus();
  scan_inject_ctrl #(.CHAIN_LEN(CL), .CAP_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // Chain model: shift on sc=1; on sc=0 hold, or invert when invertCap is set.
  logic [CL-1:0] chain = '0;
  bit invertCap = 1'b0;
  always @(posedge clk) begin
    if (bus.scan_en)    chain <= {chain[CL-2:0], bus.scan_in};
    else if (invertCap) chain <= ~chain;
  end
  assign bus.scan_out = chain[CL-1];

  // Scoreboard
  logic [CL-1:0] exp_q[$];
  int nChecks = 0;
  int nFails  = 0;

  function automatic logic [CL-1:0] model_resp(input logic [CL-1:0] pat, input logic [CW-1:0] cap, input bit inv);
    int eff;
    eff = (cap == 0) ? 1 : int'(cap);
    return (inv && (eff % 2 == 1)) ? ~pat : pat;
  endfunction

  // Driver: one campaign. Entered and left at posedge+1. Optional start
  // pulse at cycle pulseAt or in DONE, optional abort at cycle abortAt.
  task automatic run_campaign(input logic [CL-1:0] pat, input logic [CW-1:0] cap,
                              input int pulseAt, input bit pulseInDone, input int abortAt,
                              output logic [CL-1:0] resp, output int lat, output logic [CL-1:0] sinSeq,
                              output int lowCnt, output bit timedOut,
                              output logic postEn, output logic postBusy);
    resp = '0; lat = 0; sinSeq = '0; lowCnt = 0; timedOut = 1'b1;
    postEn = 1'b1; postBusy = 1'b1;
    bus.pattern = pat;
    bus.cap_cycles = cap;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 120; n++) begin
      if (abortAt > 0 && n == abortAt + 1) begin
        postEn = bus.scan_en;
        postBusy = bus.busy;
        bus.abort = 1'b0;
      end
      if (n <= CL) sinSeq = {sinSeq[CL-2:0], bus.scan_in};
      if (bus.done) begin
        resp = bus.response;
        lat = n;
        timedOut = 1'b0;
        break;
      end
      if (!bus.scan_en) lowCnt++;
      bus.start = (n == pulseAt);
      if (n == abortAt) bus.abort = 1'b1;
      @(posedge clk); #1;
    end
    bus.start = pulseInDone && !timedOut;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (bus.scan_en !== 1'b0) begin nFails++; $display("FAIL reset_scan_en got %b want 0", bus.scan_en); end
    nChecks++; if (bus.scan_in !== 1'b0) begin nFails++; $display("FAIL reset_scan_in got %b want 0", bus.scan_in); end
    nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    nChecks++; if (bus.done !== 1'b0) begin nFails++; $display("FAIL reset_done got %b want 0", bus.done); end
    nChecks++; if (bus.response !== '0) begin nFails++; $display("FAIL reset_response got %h want 0", bus.response); end
    nChecks++; if (dbgState !== IDLE) begin nFails++; $display("FAIL reset_state got %0d want IDLE", dbgState); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [CL-1:0] resp, sinSeq, e;
    int lat, lowCnt;
    bit to;
    logic pe, pb;
    invertCap = 1'b0;
    exp_q.push_back(model_resp(16'hA5C3, 4'd1, 1'b0));
    run_campaign(16'hA5C3, 4'd1, 0, 1'b0, 0, resp, lat, sinSeq, lowCnt, to, pe, pb);
    e = exp_q.pop_front();
    nChecks++; if (to) begin nFails++; $display("FAIL basic_timeout got no done want done"); end
    nChecks++; if (sinSeq !== 16'hA5C3) begin nFails++; $display("FAIL basic_scan_in_seq got %h want a5c3", sinSeq); end
    nChecks++; if (resp !== e) begin nFails++; $display("FAIL basic_response got %h want %h", resp, e); end
    nChecks++; if (lat !== 34) begin nFails++; $display("FAIL basic_latency got %0d want 34", lat); end
    nChecks++; if (lowCnt !== 1) begin nFails++; $display("FAIL basic_capture_len got %0d want 1", lowCnt); end
    nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("FAIL basic_busy_in_done got %b want 0", bus.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_invert_capture();
    logic [CL-1:0] resp, sinSeq, e;
    int lat, lowCnt;
    bit to;
    logic pe, pb;
    invertCap = 1'b1;
    exp_q.push_back(model_resp(16'hA5C3, 4'd3, 1'b1));
    run_campaign(16'hA5C3, 4'd3, 0, 1'b0, 0, resp, lat, sinSeq, lowCnt, to, pe, pb);
    e = exp_q.pop_front();
    nChecks++; if (resp !== e || to) begin nFails++; $display("FAIL invert_response got %h want %h", resp, e); end
    nChecks++; if (lat !== 36) begin nFails++; $display("FAIL invert_latency got %0d want 36", lat); end
    nChecks++; if (lowCnt !== 3) begin nFails++; $display("FAIL invert_capture_len got %0d want 3", lowCnt); end
    @(posedge clk); #1;
    nChecks++; if (bus.done !== 1'b0) begin nFails++; $display("FAIL invert_done_pulse got %b want 0", bus.done); end
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (bus.response !== e) begin nFails++; $display("FAIL invert_response_hold got %h want %h", bus.response, e); end
    invertCap = 1'b0;
  endtask

  task automatic test_abort();
    logic [CL-1:0] resp, sinSeq, e;
    int lat, lowCnt;
    bit to;
    logic pe, pb;
    // SHIFT_IN is cycles 1..16, CAPTURE 17, SHIFT_OUT starts at 18; 5th is 22.
    run_campaign(16'h1234, 4'd1, 0, 1'b0, 22, resp, lat, sinSeq, lowCnt, to, pe, pb);
    nChecks++; if (pe !== 1'b0) begin nFails++; $display("FAIL abort_scan_en got %b want 0", pe); end
    nChecks++; if (pb !== 1'b0) begin nFails++; $display("FAIL abort_busy got %b want 0", pb); end
    nChecks++; if (!to) begin nFails++; $display("FAIL abort_no_done got done at %0d want none", lat); end
    nChecks++; if (dbgState !== IDLE) begin nFails++; $display("FAIL abort_state got %0d want IDLE", dbgState); end
    exp_q.push_back(model_resp(16'hFFFF, 4'd1, 1'b0));
    run_campaign(16'hFFFF, 4'd1, 0, 1'b0, 0, resp, lat, sinSeq, lowCnt, to, pe, pb);
    e = exp_q.pop_front();
    nChecks++; if (resp !== e || to) begin nFails++; $display("FAIL abort_rerun_response got %h want %h", resp, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start();
    logic [CL-1:0] resp, sinSeq, e;
    int lat, lowCnt;
    bit to;
    logic pe, pb;
    exp_q.push_back(model_resp(16'h3C96, 4'd2, 1'b0));
    run_campaign(16'h3C96, 4'd2, 5, 1'b1, 0, resp, lat, sinSeq, lowCnt, to, pe, pb);
    e = exp_q.pop_front();
    nChecks++; if (resp !== e || to) begin nFails++; $display("FAIL ignore_response got %h want %h", resp, e); end
    nChecks++; if (lat !== 35) begin nFails++; $display("FAIL ignore_latency got %0d want 35", lat); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    nChecks++; if (dbgState !== IDLE || bus.busy !== 1'b0) begin nFails++; $display("FAIL ignore_start_in_done got state %0d busy %b want IDLE 0", dbgState, bus.busy); end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    nChecks++; if (dbgState !== IDLE || bus.busy !== 1'b0 || bus.scan_en !== 1'b0) begin nFails++; $display("FAIL start_abort_idle got state %0d busy %b want IDLE 0", dbgState, bus.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bus.pattern = 16'hBEEF;
    bus.cap_cycles = 4'd5;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    nChecks++; if (dbgState !== CAPTURE) begin nFails++; $display("FAIL rstmid_in_capture got %0d want CAPTURE", dbgState); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nChecks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin nFails++; $display("FAIL rstmid_busy_done got %b%b want 00", bus.busy, bus.done); end
    nChecks++; if (bus.scan_en !== 1'b0 || bus.scan_in !== 1'b0) begin nFails++; $display("FAIL rstmid_scan got %b%b want 00", bus.scan_en, bus.scan_in); end
    nChecks++; if (dbgState !== IDLE) begin nFails++; $display("FAIL rstmid_state got %0d want IDLE", dbgState); end
    @(posedge clk); #1;
  endtask

  task automatic test_cap_zero();
    logic [CL-1:0] resp, sinSeq, e;
    int lat, lowCnt;
    bit to;
    logic pe, pb;
    exp_q.push_back(model_resp(16'h0F0F, 4'd0, 1'b0));
    run_campaign(16'h0F0F, 4'd0, 0, 1'b0, 0, resp, lat, sinSeq, lowCnt, to, pe, pb);
    e = exp_q.pop_front();
    nChecks++; if (resp !== e || to) begin nFails++; $display("FAIL cap0_response got %h want %h", resp, e); end
    nChecks++; if (lat !== 34 || lowCnt !== 1) begin nFails++; $display("FAIL cap0_timing got lat %0d low %0d want 34 1", lat, lowCnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [CL-1:0] resp, sinSeq, e, pat;
    logic [CW-1:0] cap;
    int lat, lowCnt, effCap;
    bit to;
    logic pe, pb;
    for (int i = 0; i < 4; i++) begin
      pat = CL'($urandom_range(0, 65535));
      cap = CW'($urandom_range(0, 15));
      invertCap = 1'($urandom_range(0, 1));
      effCap = (cap == 0) ? 1 : int'(cap);
      exp_q.push_back(model_resp(pat, cap, invertCap));
      run_campaign(pat, cap, 0, 1'b0, 0, resp, lat, sinSeq, lowCnt, to, pe, pb);
      e = exp_q.pop_front();
      nChecks++; if (resp !== e || to) begin nFails++; $display("FAIL b2b_response[%0d] got %h want %h", i, resp, e); end
      nChecks++; if (lat !== 1 + 2 * CL + effCap) begin nFails++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, lat, 1 + 2 * CL + effCap); end
      @(posedge clk); #1;
    end
    invertCap = 1'b0;
  endtask

`ifdef SCAN_COMPARE_EN
  task automatic test_compare();
    logic [CL-1:0] resp, sinSeq;
    int lat, lowCnt;
    bit to;
    logic pe, pb;
    bus.expected = 16'hA5C3;
    run_campaign(16'hA5C3, 4'd1, 0, 1'b0, 0, resp, lat, sinSeq, lowCnt, to, pe, pb);
    nChecks++; if (bus.mismatch !== 1'b0 || to) begin nFails++; $display("FAIL cmp_match got %b want 0", bus.mismatch); end
    @(posedge clk); #1;
    bus.expected = 16'hA5C2;
    run_campaign(16'hA5C3, 4'd1, 0, 1'b0, 0, resp, lat, sinSeq, lowCnt, to, pe, pb);
    nChecks++; if (bus.mismatch !== 1'b1 || to) begin nFails++; $display("FAIL cmp_mismatch got %b want 1", bus.mismatch); end
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (bus.mismatch !== 1'b1) begin nFails++; $display("FAIL cmp_hold got %b want 1", bus.mismatch); end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    nChecks++; if (bus.mismatch !== 1'b0) begin nFails++; $display("FAIL cmp_clear_on_start got %b want 0", bus.mismatch); end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pattern = '0;
    bus.cap_cycles = '0;
`ifdef SCAN_COMPARE_EN
    bus.expected = '0;
`endif
    test_reset();
    test_basic();
    test_invert_capture();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    test_cap_zero();
    test_back_to_back();
`ifdef SCAN_COMPARE_EN
    test_compare();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
